conv_pool_sink: RTL and testbench

- Receiving end of the conv2 output stream: consumes the 14x14 raster stream of signed W3-bit convolution sums qualified by En.
- Applies ReLU, requantises to OW-bit signed, and performs 2x2/stride-2 max pooling.
- Emits a 7x7 pooled raster stream with valid, index and end-of-frame pulse to the next layer (same inp width as conv2).

---
 rtl/conv_pool_sink.sv | 97 +++++++++
 tb/tb_conv_pool_sink.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pool_sink.sv
// conv_pool_sink: receiving end of the conv2 stream. Applies ReLU, requantises
// to OW-bit signed, 2x2/stride-2 max pools an IMG x IMG raster and emits an
// (IMG/2) x (IMG/2) raster with index and end-of-frame pulse.
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   in_data, in_en  signed W3-bit convolution sum and its qualifier
//   out_data        registered pooled value (holds when out_en=0)
//   out_en          one-cycle pulse per pooled pixel
//   out_idx         raster index of the pooled pixel
//   frame_done      pulse coincident with the last out_en of a frame
module conv_pool_sink #(
    parameter int unsigned W3    = 21,
    parameter int unsigned OW    = 9,
    parameter int unsigned SHIFT = 8,
    parameter int unsigned IMG   = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W3-1:0] in_data,
    input  logic          in_en,
    output logic [OW-1:0] out_data,
    output logic          out_en,
    output logic [5:0]    out_idx,
    output logic          frame_done
);

    localparam int unsigned CW    = (IMG > 2) ? $clog2(IMG) : 2;
    localparam int unsigned HALF  = IMG / 2;
    localparam int unsigned NPOOL = HALF * HALF;
    localparam int unsigned SMAX  = (1 << (OW - 1)) - 1;

    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [5:0]    pidx;
    logic [OW-1:0] hold;
    logic [OW-1:0] linebuf [HALF];

    logic [W3-1:0] r_c;
    logic [W3-1:0] q_c;
    logic [OW-1:0] s_c;
    logic [OW-1:0] p_c;
    logic [OW-1:0] m_c;
    logic [OW-1:0] lb_rd_c;

    // ReLU, requantise, saturate; then horizontal and vertical max.
    // Every value here is non-negative, so unsigned compares are exact.
    always_comb begin
        r_c     = in_data[W3-1] ? '0 : in_data;
        q_c     = r_c >> SHIFT;
        s_c     = (q_c > W3'(SMAX)) ? OW'(SMAX) : q_c[OW-1:0];
        p_c     = (hold > s_c) ? hold : s_c;
        lb_rd_c = linebuf[col[CW-1:1]];
        m_c     = (lb_rd_c > p_c) ? lb_rd_c : p_c;
    end

    // Raster counters, pooling storage and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col        <= '0;
            row        <= '0;
            pidx       <= '0;
            hold       <= '0;
            out_data   <= '0;
            out_en     <= 1'b0;
            out_idx    <= '0;
            frame_done <= 1'b0;
            for (int i = 0; i < int'(HALF); i++) begin
                linebuf[i] <= '0;
            end
        end else begin
            out_en     <= 1'b0;
            frame_done <= 1'b0;
            if (in_en) begin
                if (col == CW'(IMG - 1)) begin
                    col <= '0;
                    row <= (row == CW'(IMG - 1)) ? '0 : row + CW'(1);
                end else begin
                    col <= col + CW'(1);
                end

                if (!col[0]) begin
                    hold <= s_c;
                end else if (!row[0]) begin
                    linebuf[col[CW-1:1]] <= p_c;
                end else begin
                    // Bottom-right pixel of a 2x2 window: emit the pooled value.
                    out_data   <= m_c;
                    out_en     <= 1'b1;
                    out_idx    <= pidx;
                    frame_done <= (pidx == 6'(NPOOL - 1));
                    pidx       <= (pidx == 6'(NPOOL - 1)) ? '0 : pidx + 6'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_pool_sink.sv
// Bench for conv_pool_sink: two instances (SHIFT=0 and SHIFT=8) share one
// input stream; expected pooled outputs are queued as stimulus is driven and
// checked against each instance's output stream.
module tb_conv_pool_sink;

    localparam int IMG = 14;
    localparam int NS  = IMG * IMG;

    logic        clk = 1'b0;
    logic        rst;
    logic [20:0] in_data;
    logic        in_en;

    logic [8:0] d0, d8;
    logic       e0, e8, f0, f8;
    logic [5:0] i0, i8;

    conv_pool_sink #(.W3(21), .OW(9), .SHIFT(0), .IMG(IMG)) dut0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
        .out_data(d0), .out_en(e0), .out_idx(i0), .frame_done(f0)
    );

    conv_pool_sink #(.W3(21), .OW(9), .SHIFT(8), .IMG(IMG)) dut8 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en),
        .out_data(d8), .out_en(e8), .out_idx(i8), .frame_done(f8)
    );

    always #5 clk = ~clk;

    typedef struct {
        int data;
        int idx;
        bit done;
        int due;
    } exp_t;

    typedef struct {
        int val;
        int exp0;
        int exp8;
    } vec_t;

    exp_t q0[$];
    exp_t q8[$];
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   fdcnt [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int sq(input int x, input int sh);
        int q;
        if (x < 0) return 0;
        q = x >>> sh;
        return (q > 255) ? 255 : q;
    endfunction

    function automatic int mx(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Compare one cycle of an instance's outputs with its queue.
    task automatic mon(input int id, input logic en, input logic [8:0] d,
                       input logic [5:0] ix, input logic fd);
        exp_t e;
        int   qs;
        qs = (id == 0) ? q0.size() : q8.size();
        if (en) begin
            if (fd) fdcnt[id]++;
            checks++;
            if (qs == 0) begin
                errors++;
                $display("FAIL unexpected_out_en[s%0d]: got idx=%0d data=%0d expected no output at cycle %0d",
                         id * 8, ix, d, cyc);
            end else begin
                if (id == 0) e = q0.pop_front();
                else         e = q8.pop_front();
                if (int'(d) != e.data || int'(ix) != e.idx || fd != e.done || cyc != e.due) begin
                    errors++;
                    $display("FAIL pooled_out[s%0d]: got data=%0d idx=%0d done=%0d cyc=%0d expected data=%0d idx=%0d done=%0d cyc=%0d",
                             id * 8, d, ix, fd, cyc, e.data, e.idx, e.done, e.due);
                end
            end
        end else begin
            chk($sformatf("frame_done_idle[s%0d]", id * 8), int'(fd), 0);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            mon(0, e0, d0, i0, f0);
            mon(1, e8, d8, i8, f8);
        end
    end

    // Drive n samples of a frame: value base (constant) or base+k (ramp).
    // ovr replaces computed expectations with table values.
    task automatic drive_frame(input int base, input bit ramp, input int n,
                               input bit gaps, input bit ovr,
                               input int x0, input int x8);
        int r, c, a, b, u, v;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            in_data = 21'(ramp ? base + k : base);
            in_en   = 1'b1;
            r = k / IMG;
            c = k % IMG;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                a = ramp ? base + (r - 1) * IMG + c - 1 : base;
                b = ramp ? base + (r - 1) * IMG + c     : base;
                u = ramp ? base + r * IMG + c - 1       : base;
                v = ramp ? base + k                     : base;
                e.idx  = (r / 2) * (IMG / 2) + c / 2;
                e.done = (e.idx == (IMG / 2) * (IMG / 2) - 1);
                e.due  = cyc + 1;
                e.data = ovr ? x0 : mx(mx(sq(a, 0), sq(b, 0)), mx(sq(u, 0), sq(v, 0)));
                q0.push_back(e);
                e.data = ovr ? x8 : mx(mx(sq(a, 8), sq(b, 8)), mx(sq(u, 8), sq(v, 8)));
                q8.push_back(e);
            end
            if (gaps) begin
                @(posedge clk);
                #1;
                in_en   = 1'b0;
                in_data = 21'(-7);
            end
        end
    endtask

    task automatic idle(input int n);
        @(posedge clk);
        #1;
        in_en = 1'b0;
        repeat (n) @(posedge clk);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_d0"}, int'(d0), 0);
        chk({tag, "_e0"}, int'(e0), 0);
        chk({tag, "_i0"}, int'(i0), 0);
        chk({tag, "_f0"}, int'(f0), 0);
        chk({tag, "_d8"}, int'(d8), 0);
        chk({tag, "_e8"}, int'(e8), 0);
        chk({tag, "_i8"}, int'(i8), 0);
        chk({tag, "_f8"}, int'(f8), 0);
    endtask

    vec_t tab [10];
    int   fd_base0, fd_base8;

    initial begin
        tab[0] = '{-5000,  0,   0};
        tab[1] = '{100000, 255, 255};
        tab[2] = '{2560,   255, 10};
        tab[3] = '{0,      0,   0};
        tab[4] = '{255,    255, 0};
        tab[5] = '{256,    255, 1};
        tab[6] = '{65279,  255, 254};
        tab[7] = '{65280,  255, 255};
        tab[8] = '{-1,     0,   0};
        tab[9] = '{-1048576, 0, 0};
        fdcnt[0] = 0;
        fdcnt[1] = 0;

        rst     = 1'b1;
        in_en   = 1'b0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outs("reset");
        rst = 1'b0;

        // Gap-free ramp frame.
        drive_frame(0, 1'b1, NS, 1'b0, 1'b0, 0, 0);
        idle(3);

        // Constant frames: ReLU, shift, saturation.
        for (int t = 0; t < 10; t++) begin
            drive_frame(tab[t].val, 1'b0, NS, 1'b0, 1'b1, tab[t].exp0, tab[t].exp8);
        end
        idle(3);

        // Ramp frame with a gap after every sample.
        drive_frame(0, 1'b1, NS, 1'b1, 1'b0, 0, 0);
        idle(3);

        // Abort mid-frame with reset, then a clean ramp frame.
        drive_frame(0, 1'b1, 101, 1'b0, 1'b0, 0, 0);
        idle(3);
        chk("queue_empty_before_reset", q0.size() + q8.size(), 0);
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outs("midreset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_reset_outs("midreset_hold");
        rst = 1'b0;
        q0.delete();
        q8.delete();
        drive_frame(0, 1'b1, NS, 1'b0, 1'b0, 0, 0);
        idle(3);

        // Two frames back to back, second saturating on the SHIFT=0 instance.
        fd_base0 = fdcnt[0];
        fd_base8 = fdcnt[1];
        drive_frame(0, 1'b1, NS, 1'b0, 1'b0, 0, 0);
        drive_frame(1000, 1'b1, NS, 1'b0, 1'b0, 0, 0);
        idle(5);
        chk("b2b_frame_done_s0", fdcnt[0] - fd_base0, 2);
        chk("b2b_frame_done_s8", fdcnt[1] - fd_base8, 2);

        chk("queue_drained_s0", q0.size(), 0);
        chk("queue_drained_s8", q8.size(), 0);
        chk("total_frame_done_s0", fdcnt[0], 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
